// File: rtl/othello_pkg.sv
// othello_pkg -- shared definitions for the Othello direction scanner.
//   Cell encodings, direction codes, scan modes, the per-direction dx/dy
//   delta table, colour helpers and the scanner FSM state type.
package othello_pkg;

  // Board cell encodings as stored in board memory.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Direction codes (y grows downward).
  localparam logic [2:0] DIR_U  = 3'd0;
  localparam logic [2:0] DIR_D  = 3'd1;
  localparam logic [2:0] DIR_L  = 3'd2;
  localparam logic [2:0] DIR_R  = 3'd3;
  localparam logic [2:0] DIR_UL = 3'd4;
  localparam logic [2:0] DIR_UR = 3'd5;
  localparam logic [2:0] DIR_DL = 3'd6;
  localparam logic [2:0] DIR_DR = 3'd7;

  localparam logic MODE_VALIDATE = 1'b0;
  localparam logic MODE_FLIP     = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_t;

  // Delta table: two's-complement -1/0/+1 in two bits.
  function automatic logic [1:0] dir_dx(input logic [2:0] dir);
    case (dir)
      DIR_L, DIR_UL, DIR_DL: dir_dx = 2'b11;
      DIR_R, DIR_UR, DIR_DR: dir_dx = 2'b01;
      default:               dir_dx = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dir_dy(input logic [2:0] dir);
    case (dir)
      DIR_U, DIR_UL, DIR_UR: dir_dy = 2'b11;
      DIR_D, DIR_DL, DIR_DR: dir_dy = 2'b01;
      default:               dir_dy = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] own_colour(input logic player);
    own_colour = player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_colour(input logic player);
    opp_colour = player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/scan_step.sv
// scan_step -- combinational next-position and bounds check.
//   x, y      in  3  current position
//   dir       in  3  direction code
//   nx, ny    out 3  position one step along dir (low bits, valid if on_board)
//   on_board  out 1  next position lies inside the 8x8 board
module scan_step
  import othello_pkg::*;
(
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic [2:0] dir,
  output logic [2:0] nx,
  output logic [2:0] ny,
  output logic       on_board
);

  logic [1:0] dx;
  logic [1:0] dy;
  logic [3:0] sx;
  logic [3:0] sy;

  // One extra bit catches both -1 (4'b1111) and 8 (4'b1000) as off-board.
  always_comb begin
    dx       = dir_dx(dir);
    dy       = dir_dy(dir);
    sx       = {1'b0, x} + {{2{dx[1]}}, dx};
    sy       = {1'b0, y} + {{2{dy[1]}}, dy};
    nx       = sx[2:0];
    ny       = sy[2:0];
    on_board = ~sx[3] & ~sy[3];
  end

endmodule

// File: rtl/dir_scanner.sv
// dir_scanner -- scans one board direction from an origin cell.
//   validate: counts the opponent run and records whether it is capped by
//   an own piece (valid_mask[dir], per-direction run length, flip_count).
//   flip: writes the player colour over the run recorded by the last
//   validate of that direction.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   start, mode, dir,     scan request and its parameters (sampled with start)
//   player, org_x, org_y
//   mem_addr/mem_rdata    board read port, data RD_LAT cycles after address
//   mem_wdata/mem_we      board write port
//   busy, s_done          activity flag and one-cycle completion pulse
//   valid_mask, flip_count validate results
// Build option: DIR_SCANNER_DIAG_EN enables the diagonal directions 4-7;
//   without it those directions finish immediately as invalid.
module dir_scanner
  import othello_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [2:0] dir,
  input  logic       player,
  input  logic [2:0] org_x,
  input  logic [2:0] org_y,
  output logic [5:0] mem_addr,
  input  logic [1:0] mem_rdata,
  output logic [1:0] mem_wdata,
  output logic       mem_we,
  output logic       busy,
  output logic       s_done,
  output logic [7:0] valid_mask,
  output logic [2:0] flip_count
);

`ifdef DIR_SCANNER_DIAG_EN
  localparam logic DIAG_EN = 1'b1;
`else
  localparam logic DIAG_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [2:0]      dir_q, dir_d;
  logic            player_q, player_d;
  logic [2:0]      org_x_q, org_x_d;
  logic [2:0]      org_y_q, org_y_d;
  logic [2:0]      pos_x_q, pos_x_d;
  logic [2:0]      pos_y_q, pos_y_d;
  logic [2:0]      cnt_q, cnt_d;        // run length (validate) / writes left (flip)
  logic            res_valid_q, res_valid_d;
  logic [7:0]      valid_mask_q, valid_mask_d;
  logic [2:0]      flip_count_q, flip_count_d;
  logic [7:0][2:0] cnt_reg_q, cnt_reg_d;

  logic [2:0] base_x;
  logic [2:0] base_y;
  logic [2:0] nxt_x;
  logic [2:0] nxt_y;
  logic       nxt_on;

  // The first step starts from the origin; later steps from the current cell.
  assign base_x = (state_q == S_STEP) ? org_x_q : pos_x_q;
  assign base_y = (state_q == S_STEP) ? org_y_q : pos_y_q;

  scan_step u_step (
    .x        (base_x),
    .y        (base_y),
    .dir      (dir_q),
    .nx       (nxt_x),
    .ny       (nxt_y),
    .on_board (nxt_on)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    player_d     = player_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    cnt_d        = cnt_q;
    res_valid_d  = res_valid_q;
    valid_mask_d = valid_mask_q;
    flip_count_d = flip_count_q;
    cnt_reg_d    = cnt_reg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          dir_d       = dir;
          player_d    = player;
          org_x_d     = org_x;
          org_y_d     = org_y;
          cnt_d       = 3'd0;
          res_valid_d = 1'b0;
          state_d     = S_STEP;
        end
      end
      S_STEP: begin
        pos_x_d = nxt_x;
        pos_y_d = nxt_y;
        if (!nxt_on || (dir_q[2] && !DIAG_EN)) begin
          state_d = S_DONE;
        end else if (mode_q == MODE_VALIDATE) begin
          state_d = S_REQ;
        end else if (cnt_reg_q[dir_q] == 3'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_reg_q[dir_q];
          state_d = S_WRITE;
        end
      end
      S_REQ: begin
        state_d = (RD_LAT > 1) ? S_WAIT : S_EVAL;
      end
      S_WAIT: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (mem_rdata == opp_colour(player_q)) begin
          cnt_d   = cnt_q + 3'd1;
          pos_x_d = nxt_x;
          pos_y_d = nxt_y;
          // Running off the board means the run was never capped.
          state_d = nxt_on ? S_REQ : S_DONE;
        end else begin
          res_valid_d = (mem_rdata == own_colour(player_q)) && (cnt_q != 3'd0);
          state_d     = S_DONE;
        end
      end
      S_WRITE: begin
        if (cnt_q == 3'd1 || !nxt_on) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          pos_x_d = nxt_x;
          pos_y_d = nxt_y;
        end
      end
      S_DONE: begin
        if (mode_q == MODE_VALIDATE) begin
          valid_mask_d[dir_q] = res_valid_q;
          cnt_reg_d[dir_q]    = res_valid_q ? cnt_q : 3'd0;
          flip_count_d        = cnt_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      dir_q        <= 3'd0;
      player_q     <= 1'b0;
      org_x_q      <= 3'd0;
      org_y_q      <= 3'd0;
      pos_x_q      <= 3'd0;
      pos_y_q      <= 3'd0;
      cnt_q        <= 3'd0;
      res_valid_q  <= 1'b0;
      valid_mask_q <= 8'd0;
      flip_count_q <= 3'd0;
      cnt_reg_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      player_q     <= player_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      valid_mask_q <= valid_mask_d;
      flip_count_q <= flip_count_d;
      cnt_reg_q    <= cnt_reg_d;
    end
  end

  always_comb begin
    mem_addr  = 6'd0;
    mem_wdata = CELL_EMPTY;
    if (state_q == S_REQ || state_q == S_WAIT || state_q == S_WRITE) begin
      mem_addr = {pos_y_q, pos_x_q};
    end
    if (state_q == S_WRITE) begin
      mem_wdata = own_colour(player_q);
    end
  end

  assign mem_we     = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE);
  assign s_done     = (state_q == S_DONE);
  assign valid_mask = valid_mask_q;
  assign flip_count = flip_count_q;

endmodule

// File: tb/tb_dir_scanner.sv
module tb_dir_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [2:0] dir;
  logic       player;
  logic [2:0] org_x;
  logic [2:0] org_y;
  logic [5:0] mem_addr;
  logic [1:0] mem_rdata;
  logic [1:0] mem_wdata;
  logic       mem_we;
  logic       busy;
  logic       s_done;
  logic [7:0] valid_mask;
  logic [2:0] flip_count;

  int checks = 0;
  int errors = 0;

`ifdef DIR_SCANNER_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  // Board memory seen by the DUT, plus a loader port for the bench.
  logic [1:0] mem [64];
  logic       tb_load = 1'b0;
  logic [5:0] tb_addr = 6'd0;
  logic [1:0] tb_data = 2'd0;

  // Reference model state.
  logic [1:0] ref_board [64];
  logic [7:0] exp_mask;
  int         exp_cnt [8];
  int         dxs [8] = '{0, 0, -1, 1, -1, 1, -1, 1};
  int         dys [8] = '{-1, 1, 0, 0, -1, -1, 1, 1};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (tb_load) mem[tb_addr] <= tb_data;
  end

  dir_scanner #(.RD_LAT(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .dir        (dir),
    .player     (player),
    .org_x      (org_x),
    .org_y      (org_y),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .busy       (busy),
    .s_done     (s_done),
    .valid_mask (valid_mask),
    .flip_count (flip_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cell(input int x, input int y, input logic [1:0] v);
    ref_board[y*8+x] = v;
    tb_load = 1'b1;
    tb_addr = 6'(y*8+x);
    tb_data = v;
    @(posedge clock); #1;
    tb_load = 1'b0;
  endtask

  // Walk the line from the origin on the reference board.
  function automatic void ref_scan(input int ox, input int oy, input int d, input int pl,
                                   output int reads, output int cnt, output bit ok);
    int x, y;
    logic [1:0] own, opp, c;
    own = (pl != 0) ? 2'b10 : 2'b01;
    opp = (pl != 0) ? 2'b01 : 2'b10;
    reads = 0; cnt = 0; ok = 1'b0;
    if (d >= 4 && !DIAG) return;
    x = ox + dxs[d];
    y = oy + dys[d];
    while (x >= 0 && x < 8 && y >= 0 && y < 8) begin
      reads++;
      c = ref_board[y*8+x];
      if (c == opp) cnt++;
      else begin
        ok = (c == own) && (cnt > 0);
        return;
      end
      x += dxs[d];
      y += dys[d];
    end
  endfunction

  task automatic run_op(input bit m, input int d, input int pl, input int ox, input int oy,
                        input string tag);
    int reads, cnt, exp_done, got_done, c;
    bit ok;
    logic [1:0] own;
    logic [7:0] exp_w [$];
    logic [7:0] got_w [$];
    own = (pl != 0) ? 2'b10 : 2'b01;
    reads = 0; cnt = 0; ok = 1'b0;
    if (!m) begin
      ref_scan(ox, oy, d, pl, reads, cnt, ok);
      exp_done = 2*reads + 2;
    end else begin
      c = exp_cnt[d];
      exp_done = c + 2;
      for (int i = 1; i <= c; i++)
        exp_w.push_back({6'((oy + i*dys[d])*8 + ox + i*dxs[d]), own});
    end
    start = 1'b1; mode = m; dir = 3'(d); player = pl[0];
    org_x = 3'(ox); org_y = 3'(oy);
    got_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        // Start stays high while busy with scrambled parameters: must be ignored.
        chk({tag, "_busy"}, busy, 1);
        mode = 1'($urandom_range(0, 1));
        dir = 3'($urandom_range(0, 7));
        player = 1'($urandom_range(0, 1));
        org_x = 3'($urandom_range(0, 7));
        org_y = 3'($urandom_range(0, 7));
      end
      if (k == 2) start = 1'b0;
      if (mem_we) got_w.push_back({mem_addr, mem_wdata});
      if (s_done) begin
        got_done = k;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, got_done, exp_done);
    chk({tag, "_nwrites"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      chk({tag, "_write"}, got_w[i], exp_w[i]);
    @(posedge clock); #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_addr"}, mem_addr, 0);
    if (!m) begin
      exp_mask[d] = ok;
      exp_cnt[d] = ok ? cnt : 0;
      chk({tag, "_mask"}, valid_mask, exp_mask);
      if (ok || reads == 0) chk({tag, "_flip_count"}, flip_count, cnt);
    end else begin
      foreach (exp_w[i]) ref_board[exp_w[i][7:2]] = exp_w[i][1:0];
      chk({tag, "_mask_kept"}, valid_mask, exp_mask);
    end
    $display("op %s mode=%0d dir=%0d pl=%0d org=(%0d,%0d) done@%0d writes=%0d mask=%02h",
             tag, m, d, pl, ox, oy, got_done, got_w.size(), valid_mask);
  endtask

  initial begin
    int ox, oy, pl, d;
    reset = 1'b0; start = 1'b0; mode = 1'b0; dir = 3'd0; player = 1'b0;
    org_x = 3'd0; org_y = 3'd0;
    exp_mask = 8'd0;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 64; i++) set_cell(i % 8, i / 8, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mask", valid_mask, 0);
    chk("rst_fc", flip_count, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Off-board first step.
    run_op(0, 0, 0, 0, 0, "offboard_u");
    // Short capped run downward, then flip it.
    set_cell(3, 3, 2'b10);
    set_cell(3, 4, 2'b01);
    run_op(0, 1, 0, 3, 2, "val_d");
    chk("val_d_mask1", valid_mask[1], 1);
    chk("val_d_fc", flip_count, 1);
    run_op(1, 1, 0, 3, 2, "flip_d");
    chk("flip_d_cell", mem[27], 2'b01);
    // Uncapped run to the board edge.
    for (int x = 1; x < 8; x++) set_cell(x, 4, 2'b01);
    run_op(0, 3, 1, 0, 4, "edge_r");
    // Diagonal UR: scanned or immediately invalid depending on the build.
    set_cell(4, 3, 2'b10);
    run_op(0, 5, 1, 2, 5, "diag_ur");

    // Reset in the middle of a three-cell flip.
    set_cell(1, 0, 2'b10); set_cell(2, 0, 2'b10); set_cell(3, 0, 2'b10);
    set_cell(4, 0, 2'b01);
    run_op(0, 3, 0, 0, 0, "mid_val");
    start = 1'b1; mode = 1'b1; dir = 3'd3; player = 1'b0; org_x = 3'd0; org_y = 3'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("mid_first_we", mem_we, 1);
    chk("mid_first_addr", mem_addr, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_mask", valid_mask, 0);
    chk("mid_rst_done", s_done, 0);
    $display("op mid_flip_reset busy=%0d we=%0d mask=%02h", busy, mem_we, valid_mask);
    ref_board[1] = 2'b01;
    exp_mask = 8'd0;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    run_op(1, 3, 0, 0, 0, "post_rst_flip");

    // Random boards: validate all directions from one origin, then flip two.
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 64; i++) set_cell(i % 8, i / 8, 2'($urandom_range(0, 2)));
      ox = int'($urandom_range(0, 7));
      oy = int'($urandom_range(0, 7));
      pl = int'($urandom_range(0, 1));
      for (int dd = 0; dd < 8; dd++) run_op(0, dd, pl, ox, oy, "rnd_val");
      for (int f = 0; f < 2; f++) begin
        d = int'($urandom_range(0, 7));
        run_op(1, d, pl, ox, oy, "rnd_flip");
      end
      for (int i = 0; i < 64; i++) chk("rnd_board", mem[i], ref_board[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
